// File: rtl/wb_merge.sv
// Writeback merge stage: buffers 8/16/32-bit x86 results in a small FIFO and
// merges each one into the current register value before writing it back.
module wb_merge #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_idx,
    input  logic [1:0]  in_size,
    input  logic [31:0] in_data,
    input  logic        hold,
    output logic [2:0]  rd_idx,
    input  logic [31:0] rd_val,
    output logic        we,
    output logic [2:0]  dst_idx,
    output logic [31:0] w_val,
    output logic        busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [2:0]    fifo_idx  [DEPTH];
    logic [1:0]    fifo_size [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic        empty;
    logic        push;
    logic        pop;
    logic [2:0]  head_idx;
    logic [1:0]  head_size;
    logic [31:0] head_data;
    logic [2:0]  head_phys;
    logic [31:0] old_val;
    logic [31:0] merged;

    assign empty     = (count == '0);
    assign in_ready  = (count < FULL) && !rst;
    assign push      = in_valid && in_ready;
    assign pop       = !empty && !hold;
    assign busy      = !empty || we;

    assign head_idx  = fifo_idx[rd_ptr];
    assign head_size = fifo_size[rd_ptr];
    assign head_data = fifo_data[rd_ptr];

    // AH/CH/DH/BH live in bits 15:8 of EAX/ECX/EDX/EBX.
    assign head_phys = (head_size == 2'b00 && head_idx[2]) ? {1'b0, head_idx[1:0]} : head_idx;
    assign rd_idx    = empty ? 3'd0 : head_phys;

    // The register file has not yet captured the write in flight, so take it from w_val.
    assign old_val   = (we && dst_idx == head_phys) ? w_val : rd_val;

    always_comb begin
        merged = head_data;
        case (head_size)
            2'b00: begin
                if (head_idx[2])
                    merged = {old_val[31:16], head_data[7:0], old_val[7:0]};
                else
                    merged = {old_val[31:8], head_data[7:0]};
            end
            2'b01:   merged = {old_val[31:16], head_data[15:0]};
            default: merged = head_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_idx[wr_ptr]  <= in_idx;
            fifo_size[wr_ptr] <= in_size;
            fifo_data[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            we      <= 1'b0;
            dst_idx <= 3'd0;
            w_val   <= 32'd0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            we <= pop;
            if (pop) begin
                dst_idx <= head_phys;
                w_val   <= merged;
            end
        end
    end

endmodule

// File: tb/tb_wb_merge.sv
// Directed bench for wb_merge: a behavioural register file sits behind the
// write port and every check compares against hand-computed values.
module tb_wb_merge;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_idx;
    logic [1:0]  in_size;
    logic [31:0] in_data;
    logic        hold;
    logic [2:0]  rd_idx;
    logic [31:0] rd_val;
    logic        we;
    logic [2:0]  dst_idx;
    logic [31:0] w_val;
    logic        busy;

    logic [31:0] regs [8];
    logic        pre_en;
    logic [2:0]  pre_idx;
    logic [31:0] pre_val;
    int          we_count = 0;
    int          total = 0;
    int          bad = 0;
    int          we_snap;

    always #5 clk = ~clk;

    wb_merge #(.DEPTH(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_idx   (in_idx),
        .in_size  (in_size),
        .in_data  (in_data),
        .hold     (hold),
        .rd_idx   (rd_idx),
        .rd_val   (rd_val),
        .we       (we),
        .dst_idx  (dst_idx),
        .w_val    (w_val),
        .busy     (busy)
    );

    assign rd_val = regs[rd_idx];

    // Register file model; preload is only used while no write is in flight.
    always @(posedge clk) begin
        if (pre_en)
            regs[pre_idx] <= pre_val;
        if (we) begin
            regs[dst_idx] <= w_val;
            we_count <= we_count + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [2:0] idx, input logic [31:0] val);
        pre_en  = 1'b1;
        pre_idx = idx;
        pre_val = val;
        tick();
        pre_en  = 1'b0;
    endtask

    // Presents one request for a single edge (the acceptance edge E0).
    task automatic applyStimulus(input logic [2:0] idx, input logic [1:0] size, input logic [31:0] data);
        in_valid = 1'b1;
        in_idx   = idx;
        in_size  = size;
        in_data  = data;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        in_idx   = 3'd3;
        in_size  = 2'b10;
        in_data  = 32'h5555_5555;
        hold     = 1'b0;
        pre_en   = 1'b0;
        pre_idx  = 3'd0;
        pre_val  = 32'd0;

        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("rst_we", {31'd0, we}, 32'd0);
            checkOutput("rst_dst", {29'd0, dst_idx}, 32'd0);
            checkOutput("rst_wval", w_val, 32'd0);
            checkOutput("rst_busy", {31'd0, busy}, 32'd0);
            checkOutput("rst_ready", {31'd0, in_ready}, 32'd0);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("post_rst_ready", {31'd0, in_ready}, 32'd1);
        tick();
        checkOutput("post_rst_we", {31'd0, we}, 32'd0);

        applyStimulus(3'd0, 2'b10, 32'hDEAD_BEEF);
        checkOutput("dw_e0_we", {31'd0, we}, 32'd0);
        tick();
        checkOutput("dw_we", {31'd0, we}, 32'd1);
        checkOutput("dw_dst", {29'd0, dst_idx}, 32'd0);
        checkOutput("dw_wval", w_val, 32'hDEAD_BEEF);
        tick();
        checkOutput("dw_we_fall", {31'd0, we}, 32'd0);
        checkOutput("dw_reg", regs[0], 32'hDEAD_BEEF);
        checkOutput("no_write_from_rst", regs[3], 32'h0000_0000);

        preload(3'd1, 32'hCAFE_BABE);
        applyStimulus(3'd5, 2'b00, 32'h0000_0012);
        checkOutput("hb_rd_idx", {29'd0, rd_idx}, 32'd1);
        tick();
        checkOutput("hb_dst", {29'd0, dst_idx}, 32'd1);
        checkOutput("hb_wval", w_val, 32'hCAFE_12BE);
        tick();

        preload(3'd2, 32'h1234_5678);
        applyStimulus(3'd2, 2'b01, 32'hFFFF_BEEF);
        tick();
        checkOutput("wd_dst", {29'd0, dst_idx}, 32'd2);
        checkOutput("wd_wval", w_val, 32'h1234_BEEF);
        tick();

        preload(3'd0, 32'h0000_0000);
        in_valid = 1'b1;
        in_idx   = 3'd0;
        in_size  = 2'b10;
        in_data  = 32'h1122_3344;
        tick();
        in_idx   = 3'd4;
        in_size  = 2'b00;
        in_data  = 32'h0000_00AA;
        tick();
        in_valid = 1'b0;
        checkOutput("bp_first_wval", w_val, 32'h1122_3344);
        tick();
        checkOutput("bp_we", {31'd0, we}, 32'd1);
        checkOutput("bp_dst", {29'd0, dst_idx}, 32'd0);
        checkOutput("bp_wval", w_val, 32'h1122_AA44);
        tick();
        checkOutput("bp_reg", regs[0], 32'h1122_AA44);

        preload(3'd3, 32'h0BAD_F00D);
        hold = 1'b1;
        applyStimulus(3'd0, 2'b10, 32'h0000_0001);
        applyStimulus(3'd1, 2'b10, 32'h0000_0002);
        checkOutput("full_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("full_we", {31'd0, we}, 32'd0);
        checkOutput("full_busy", {31'd0, busy}, 32'd1);
        tick();
        checkOutput("hold_we", {31'd0, we}, 32'd0);
        // Full FIFO must refuse a push even though this edge pops.
        hold     = 1'b0;
        in_valid = 1'b1;
        in_idx   = 3'd3;
        in_size  = 2'b10;
        in_data  = 32'h0000_0033;
        tick();
        in_valid = 1'b0;
        checkOutput("drain1_we", {31'd0, we}, 32'd1);
        checkOutput("drain1_dst", {29'd0, dst_idx}, 32'd0);
        checkOutput("drain1_wval", w_val, 32'h0000_0001);
        tick();
        checkOutput("drain2_we", {31'd0, we}, 32'd1);
        checkOutput("drain2_dst", {29'd0, dst_idx}, 32'd1);
        checkOutput("drain2_wval", w_val, 32'h0000_0002);
        tick();
        checkOutput("drain_we_fall", {31'd0, we}, 32'd0);
        checkOutput("drain_busy", {31'd0, busy}, 32'd0);
        tick();
        checkOutput("refused_reg", regs[3], 32'h0BAD_F00D);

        preload(3'd6, 32'h6666_0000);
        preload(3'd7, 32'h7777_0000);
        hold = 1'b1;
        applyStimulus(3'd6, 2'b10, 32'h0000_0066);
        applyStimulus(3'd7, 2'b10, 32'h0000_0077);
        we_snap = we_count;
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        hold = 1'b0;
        #1;
        checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("mid_rst_we", {31'd0, we}, 32'd0);
        end
        checkOutput("mid_rst_wecount", we_count, we_snap);
        checkOutput("mid_rst_reg6", regs[6], 32'h6666_0000);
        checkOutput("mid_rst_reg7", regs[7], 32'h7777_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
